// File: rtl/ro_pair_measure_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ro_pair_measure_ctrl_if
// Description : Bundles the challenge handshake, oscillator select/enable,
//               sampled oscillator input and response handshake of the RO
//               pair measurement controller.
//               slave  : controller side (accepts challenges, drives response)
//               master : environment side (issues challenges, takes response)
// Ports       : chal_valid/chal_ready/chal_a/chal_b - challenge handshake
//               sel/ro_en/ro_in                     - oscillator bank control
//               resp_valid/resp_ready/resp_bit/
//               resp_tie/count_a/count_b            - response handshake
//               busy                                - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface ro_pair_measure_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             chal_valid;
    logic             chal_ready;
    logic [3:0]       chal_a;
    logic [3:0]       chal_b;
    logic [3:0]       sel;
    logic             ro_en;
    logic             ro_in;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_bit;
    logic             resp_tie;
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;
    logic             busy;

    modport slave (
        input  chal_valid, chal_a, chal_b, ro_in, resp_ready,
        output chal_ready, sel, ro_en, resp_valid, resp_bit, resp_tie,
               count_a, count_b, busy
    );

    modport master (
        output chal_valid, chal_a, chal_b, ro_in, resp_ready,
        input  chal_ready, sel, ro_en, resp_valid, resp_bit, resp_tie,
               count_a, count_b, busy
    );
endinterface
`default_nettype wire

// File: rtl/ro_pair_measure_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ro_pair_measure_ctrl
// Description : Ring-oscillator pair measurement controller. Accepts a
//               challenge of two 4-bit oscillator indices, selects each
//               oscillator in turn, lets it settle, counts its rising edges
//               over a fixed window and returns a one-bit response
//               (count_a > count_b) plus a tie flag and both raw counts.
// Parameters  : SETTLE - cycles held after each select change (>= 3)
//               WINDOW - count window length in clock cycles (>= 1)
//               CNT_W  - edge counter width (saturating)
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - ro_pair_measure_ctrl_if.slave (challenge in,
//                        oscillator select/enable out, ro_in in,
//                        response out, busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module ro_pair_measure_ctrl #(
    parameter int SETTLE = 4,
    parameter int WINDOW = 1024,
    parameter int CNT_W  = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    ro_pair_measure_ctrl_if.slave      bus
);

    // One phase counter serves both settle and count windows, so it is sized
    // for the longer of the two.
    localparam int PH_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int PH_W   = $clog2(PH_MAX) + 1;

    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE - 1);
    localparam logic [PH_W-1:0]  WINDOW_LAST = PH_W'(WINDOW - 1);
    localparam logic [PH_W-1:0]  PH_ONE      = PH_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETTLE_A = 3'd1,
        S_COUNT_A  = 3'd2,
        S_SETTLE_B = 3'd3,
        S_COUNT_B  = 3'd4,
        S_COMPARE  = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t           state_q;
    logic [PH_W-1:0]  phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       chal_b_q;
    logic [3:0]       sel_q;
    logic             ro_en_q;
    logic             resp_valid_q;
    logic             resp_bit_q;
    logic             resp_tie_q;
    logic [CNT_W-1:0] count_a_q;
    logic [CNT_W-1:0] count_b_q;

    // ro_in is asynchronous: two flops resolve metastability, the third holds
    // the previous synchronised level for rising-edge detection.
    logic             meta_q;
    logic             sync_q;
    logic             prev_q;
    logic             edge_w;

    assign edge_w = sync_q & ~prev_q;

    // Saturating increment: the counter sticks at all-ones instead of
    // wrapping, so an over-range oscillator still compares as "large".
    always_comb begin
        cnt_d = cnt_q;
        if (edge_w && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            cnt_q        <= '0;
            chal_b_q     <= '0;
            sel_q        <= '0;
            ro_en_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_bit_q   <= 1'b0;
            resp_tie_q   <= 1'b0;
            count_a_q    <= '0;
            count_b_q    <= '0;
            meta_q       <= 1'b0;
            sync_q       <= 1'b0;
            prev_q       <= 1'b0;
        end else begin
            meta_q <= bus.ro_in;
            sync_q <= meta_q;
            prev_q <= sync_q;

            case (state_q)
                S_IDLE: begin
                    // chal_ready is high whenever idle, so valid alone accepts.
                    if (bus.chal_valid) begin
                        chal_b_q <= bus.chal_b;
                        sel_q    <= bus.chal_a;
                        ro_en_q  <= 1'b1;
                        phase_q  <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_SETTLE_A;
                    end
                end

                S_SETTLE_A, S_SETTLE_B: begin
                    // Edges during settle reflect start-up and stale
                    // synchroniser contents, so they are discarded.
                    cnt_q <= '0;
                    if (phase_q == SETTLE_LAST) begin
                        phase_q <= '0;
                        state_q <= (state_q == S_SETTLE_A) ? S_COUNT_A : S_COUNT_B;
                    end else begin
                        phase_q <= phase_q + PH_ONE;
                    end
                end

                S_COUNT_A: begin
                    if (phase_q == WINDOW_LAST) begin
                        // Include an edge seen in the final window cycle.
                        count_a_q <= cnt_d;
                        cnt_q     <= '0;
                        phase_q   <= '0;
                        sel_q     <= chal_b_q;
                        state_q   <= S_SETTLE_B;
                    end else begin
                        cnt_q   <= cnt_d;
                        phase_q <= phase_q + PH_ONE;
                    end
                end

                S_COUNT_B: begin
                    if (phase_q == WINDOW_LAST) begin
                        count_b_q <= cnt_d;
                        cnt_q     <= '0;
                        phase_q   <= '0;
                        ro_en_q   <= 1'b0;
                        state_q   <= S_COMPARE;
                    end else begin
                        cnt_q   <= cnt_d;
                        phase_q <= phase_q + PH_ONE;
                    end
                end

                S_COMPARE: begin
                    resp_bit_q   <= (count_a_q > count_b_q);
                    resp_tie_q   <= (count_a_q == count_b_q);
                    resp_valid_q <= 1'b1;
                    state_q      <= S_DONE;
                end

                S_DONE: begin
                    // Response data is left in place after the handshake.
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.chal_ready = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.sel        = sel_q;
    assign bus.ro_en      = ro_en_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_bit   = resp_bit_q;
    assign bus.resp_tie   = resp_tie_q;
    assign bus.count_a    = count_a_q;
    assign bus.count_b    = count_b_q;

endmodule
`default_nettype wire

// File: tb/tb_ro_pair_measure_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ro_pair_measure_ctrl
// Description : Directed testbench for ro_pair_measure_ctrl. A behavioural
//               oscillator bank gives each index a fixed period in clock
//               cycles; expected counts are window/period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ro_pair_measure_ctrl;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;
    int unsigned ro_tick;

    ro_pair_measure_ctrl_if #(.CNT_W(16)) bus0 ();
    ro_pair_measure_ctrl_if #(.CNT_W(4))  bus1 ();

    ro_pair_measure_ctrl #(.SETTLE(4), .WINDOW(1024), .CNT_W(16)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    ro_pair_measure_ctrl #(.SETTLE(4), .WINDOW(64), .CNT_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator periods in clk cycles per index.
    function automatic int unsigned ro_period(input logic [3:0] idx);
        case (idx)
            4'd3:    return 8;
            4'd9:    return 10;
            4'd5:    return 8;
            4'd7:    return 4;
            default: return 6;
        endcase
    endfunction

    function automatic logic ro_level(input logic [3:0] idx, input int unsigned t);
        int unsigned p;
        p = ro_period(idx);
        return ((t % p) < (p / 2));
    endfunction

    initial ro_tick = 0;
    always @(negedge clk) ro_tick = ro_tick + 1;

    assign bus0.ro_in = bus0.ro_en & ro_level(bus0.sel, ro_tick);
    assign bus1.ro_in = bus1.ro_en & ro_level(bus1.sel, ro_tick);

    // Issue one challenge on bus0 and wait for resp_valid; lat counts edges
    // after the accepting edge. sel/ro_en are sampled mid COUNT_A/COUNT_B.
    task automatic run0(input logic [3:0] a, input logic [3:0] b, output int lat,
                        output logic [3:0] sa, output logic [3:0] sb, output logic en);
        bus0.chal_a     = a;
        bus0.chal_b     = b;
        bus0.chal_valid = 1'b1;
        @(posedge clk);
        #1 bus0.chal_valid = 1'b0;
        lat = 0;
        sa  = 4'hx;
        sb  = 4'hx;
        en  = 1'b0;
        while (!bus0.resp_valid && lat < 5000) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 500) begin
                sa = bus0.sel;
                en = bus0.ro_en;
            end
            if (lat == 1500) sb = bus0.sel;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (bus0.sel !== 4'd0) $display("FAIL reset_sel got %0d exp 0", bus0.sel); else pass_cnt++;
        total_cnt++; if (bus0.ro_en !== 1'b0) $display("FAIL reset_ro_en got %b exp 0", bus0.ro_en); else pass_cnt++;
        total_cnt++; if (bus0.resp_valid !== 1'b0 || bus0.resp_bit !== 1'b0 || bus0.resp_tie !== 1'b0)
            $display("FAIL reset_resp got v%b b%b t%b exp 000", bus0.resp_valid, bus0.resp_bit, bus0.resp_tie); else pass_cnt++;
        total_cnt++; if (bus0.count_a !== 16'd0 || bus0.count_b !== 16'd0)
            $display("FAIL reset_counts got %0d/%0d exp 0/0", bus0.count_a, bus0.count_b); else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++; if (bus0.chal_ready !== 1'b1) $display("FAIL reset_chal_ready got %b exp 1", bus0.chal_ready); else pass_cnt++;
        total_cnt++; if (bus0.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus0.busy); else pass_cnt++;
    endtask

    task automatic test_basic();
        int lat; logic [3:0] sa, sb; logic en;
        run0(4'd3, 4'd9, lat, sa, sb, en);
        total_cnt++; if (lat !== 2057) $display("FAIL basic_latency got %0d exp 2057", lat); else pass_cnt++;
        total_cnt++; if (!(bus0.count_a >= 127 && bus0.count_a <= 129)) $display("FAIL basic_count_a got %0d exp 128+-1", bus0.count_a); else pass_cnt++;
        total_cnt++; if (!(bus0.count_b >= 101 && bus0.count_b <= 103)) $display("FAIL basic_count_b got %0d exp 102+-1", bus0.count_b); else pass_cnt++;
        total_cnt++; if (bus0.resp_bit !== 1'b1 || bus0.resp_tie !== 1'b0)
            $display("FAIL basic_resp got bit%b tie%b exp bit1 tie0", bus0.resp_bit, bus0.resp_tie); else pass_cnt++;
        total_cnt++; if (sa !== 4'd3 || sb !== 4'd9) $display("FAIL basic_sel got %0d,%0d exp 3,9", sa, sb); else pass_cnt++;
        total_cnt++; if (en !== 1'b1 || bus0.ro_en !== 1'b0)
            $display("FAIL basic_ro_en got count%b done%b exp 1,0", en, bus0.ro_en); else pass_cnt++;
        total_cnt++; if (bus0.chal_ready !== 1'b0) $display("FAIL basic_chal_ready_done got %b exp 0", bus0.chal_ready); else pass_cnt++;
        bus0.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus0.resp_ready = 1'b0;
        total_cnt++; if (bus0.resp_valid !== 1'b0 || bus0.busy !== 1'b0)
            $display("FAIL basic_handshake got valid%b busy%b exp 0,0", bus0.resp_valid, bus0.busy); else pass_cnt++;
        total_cnt++; if (bus0.resp_bit !== 1'b1) $display("FAIL basic_hold_bit got %b exp 1", bus0.resp_bit); else pass_cnt++;
    endtask

    // resp_ready is held high for the whole run; it must be ignored until DONE.
    task automatic test_swapped();
        int lat; logic [3:0] sa, sb; logic en;
        bus0.resp_ready = 1'b1;
        run0(4'd9, 4'd3, lat, sa, sb, en);
        total_cnt++; if (lat !== 2057) $display("FAIL swap_latency got %0d exp 2057", lat); else pass_cnt++;
        total_cnt++; if (!(bus0.count_a >= 101 && bus0.count_a <= 103)) $display("FAIL swap_count_a got %0d exp 102+-1", bus0.count_a); else pass_cnt++;
        total_cnt++; if (!(bus0.count_b >= 127 && bus0.count_b <= 129)) $display("FAIL swap_count_b got %0d exp 128+-1", bus0.count_b); else pass_cnt++;
        total_cnt++; if (bus0.resp_bit !== 1'b0 || bus0.resp_tie !== 1'b0)
            $display("FAIL swap_resp got bit%b tie%b exp bit0 tie0", bus0.resp_bit, bus0.resp_tie); else pass_cnt++;
        @(posedge clk);
        #1 bus0.resp_ready = 1'b0;
        total_cnt++; if (bus0.resp_valid !== 1'b0) $display("FAIL swap_handshake got %b exp 0", bus0.resp_valid); else pass_cnt++;
    endtask

    task automatic test_same_index();
        int lat; logic [3:0] sa, sb; logic en; int diff; logic exp_tie, exp_bit;
        run0(4'd5, 4'd5, lat, sa, sb, en);
        diff = int'(bus0.count_a) - int'(bus0.count_b);
        exp_tie = (diff == 0);
        exp_bit = (diff > 0);
        total_cnt++; if (diff < -1 || diff > 1) $display("FAIL same_diff got %0d exp within 1", diff); else pass_cnt++;
        total_cnt++; if (!(bus0.count_a >= 127 && bus0.count_a <= 129)) $display("FAIL same_count_a got %0d exp 128+-1", bus0.count_a); else pass_cnt++;
        total_cnt++; if (bus0.resp_tie !== exp_tie) $display("FAIL same_tie got %b exp %b", bus0.resp_tie, exp_tie); else pass_cnt++;
        total_cnt++; if (bus0.resp_bit !== exp_bit) $display("FAIL same_bit got %b exp %b", bus0.resp_bit, exp_bit); else pass_cnt++;
        bus0.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus0.resp_ready = 1'b0;
    endtask

    // Narrow-counter instance: period 4 over 64 cycles gives 16 edges, which
    // must stick at 15 rather than wrapping to 0.
    task automatic test_saturation();
        int lat;
        bus1.chal_a     = 4'd7;
        bus1.chal_b     = 4'd3;
        bus1.chal_valid = 1'b1;
        @(posedge clk);
        #1 bus1.chal_valid = 1'b0;
        lat = 0;
        while (!bus1.resp_valid && lat < 1000) begin
            @(posedge clk);
            lat++;
            #1;
        end
        total_cnt++; if (lat !== 137) $display("FAIL sat_latency got %0d exp 137", lat); else pass_cnt++;
        total_cnt++; if (bus1.count_a !== 4'd15) $display("FAIL sat_count_a got %0d exp 15", bus1.count_a); else pass_cnt++;
        total_cnt++; if (!(bus1.count_b >= 7 && bus1.count_b <= 9)) $display("FAIL sat_count_b got %0d exp 8+-1", bus1.count_b); else pass_cnt++;
        total_cnt++; if (bus1.resp_bit !== 1'b1 || bus1.resp_tie !== 1'b0)
            $display("FAIL sat_resp got bit%b tie%b exp bit1 tie0", bus1.resp_bit, bus1.resp_tie); else pass_cnt++;
        bus1.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus1.resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        int lat; logic [3:0] sa, sb; logic en;
        bus0.chal_a     = 4'd3;
        bus0.chal_b     = 4'd9;
        bus0.chal_valid = 1'b1;
        @(posedge clk);
        #1 bus0.chal_valid = 1'b0;
        repeat (1500) @(posedge clk);
        #3;
        total_cnt++; if (bus0.sel !== 4'd9 || bus0.count_a === 16'd0)
            $display("FAIL rstmid_precond got sel%0d cnt_a%0d exp sel9 nonzero", bus0.sel, bus0.count_a); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (bus0.sel !== 4'd0 || bus0.ro_en !== 1'b0)
            $display("FAIL rstmid_sel_en got sel%0d en%b exp 0,0", bus0.sel, bus0.ro_en); else pass_cnt++;
        total_cnt++; if (bus0.count_a !== 16'd0 || bus0.count_b !== 16'd0)
            $display("FAIL rstmid_counts got %0d/%0d exp 0/0", bus0.count_a, bus0.count_b); else pass_cnt++;
        total_cnt++; if (bus0.busy !== 1'b0 || bus0.chal_ready !== 1'b1 || bus0.resp_valid !== 1'b0)
            $display("FAIL rstmid_state got busy%b rdy%b v%b exp 0,1,0", bus0.busy, bus0.chal_ready, bus0.resp_valid); else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        run0(4'd3, 4'd9, lat, sa, sb, en);
        total_cnt++; if (lat !== 2057) $display("FAIL rstmid_latency got %0d exp 2057", lat); else pass_cnt++;
        total_cnt++; if (bus0.resp_bit !== 1'b1 || !(bus0.count_a >= 127 && bus0.count_a <= 129))
            $display("FAIL rstmid_result got bit%b cnt_a%0d exp 1,128+-1", bus0.resp_bit, bus0.count_a); else pass_cnt++;
        bus0.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus0.resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat; int bad; logic [15:0] snap_a, snap_b; logic snap_bit;
        bus0.chal_a     = 4'd9;
        bus0.chal_b     = 4'd3;
        bus0.chal_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        #1;
        while (!bus0.resp_valid && lat < 5000) begin
            @(posedge clk);
            lat++;
            #1;
        end
        total_cnt++; if (lat !== 2057) $display("FAIL b2b_latency1 got %0d exp 2057", lat); else pass_cnt++;
        total_cnt++; if (bus0.resp_bit !== 1'b0) $display("FAIL b2b_bit1 got %b exp 0", bus0.resp_bit); else pass_cnt++;
        snap_a   = bus0.count_a;
        snap_b   = bus0.count_b;
        snap_bit = bus0.resp_bit;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (bus0.resp_valid !== 1'b1 || bus0.chal_ready !== 1'b0 || bus0.resp_bit !== snap_bit ||
                bus0.count_a !== snap_a || bus0.count_b !== snap_b) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL b2b_stable got %0d bad cycles exp 0", bad); else pass_cnt++;
        bus0.chal_a     = 4'd3;
        bus0.chal_b     = 4'd9;
        bus0.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus0.resp_ready = 1'b0;
        total_cnt++; if (bus0.resp_valid !== 1'b0 || bus0.chal_ready !== 1'b1 || bus0.busy !== 1'b0)
            $display("FAIL b2b_idle got v%b rdy%b busy%b exp 0,1,0", bus0.resp_valid, bus0.chal_ready, bus0.busy); else pass_cnt++;
        @(posedge clk);
        #1 bus0.chal_valid = 1'b0;
        total_cnt++; if (bus0.busy !== 1'b1 || bus0.sel !== 4'd3 || bus0.ro_en !== 1'b1)
            $display("FAIL b2b_accept got busy%b sel%0d en%b exp 1,3,1", bus0.busy, bus0.sel, bus0.ro_en); else pass_cnt++;
        lat = 0;
        while (!bus0.resp_valid && lat < 5000) begin
            @(posedge clk);
            lat++;
            #1;
        end
        total_cnt++; if (lat !== 2057) $display("FAIL b2b_latency2 got %0d exp 2057", lat); else pass_cnt++;
        total_cnt++; if (bus0.resp_bit !== 1'b1) $display("FAIL b2b_bit2 got %b exp 1", bus0.resp_bit); else pass_cnt++;
        bus0.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus0.resp_ready = 1'b0;
    endtask

    initial begin
        pass_cnt        = 0;
        total_cnt       = 0;
        rst_n           = 1'b0;
        bus0.chal_valid = 1'b0;
        bus0.chal_a     = 4'd0;
        bus0.chal_b     = 4'd0;
        bus0.resp_ready = 1'b0;
        bus1.chal_valid = 1'b0;
        bus1.chal_a     = 4'd0;
        bus1.chal_b     = 4'd0;
        bus1.resp_ready = 1'b0;
        test_reset();
        test_basic();
        test_swapped();
        test_same_index();
        test_saturation();
        test_reset_mid_count();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
